datapath_controller: RTL and testbench
======================================

// Module: datapath_controller
// PURPOSE
//  Multi-cycle sequencer for the 4-bit datapath (4 x 4-bit register file + ALU).
//  Accepts 8-bit instructions over a valid/ready handshake, strobes the instruction
//  register load, decodes the {mnm, wr_addr_mnm, rd_addr_wr_data} fields and drives
//  register-file, ALU, immediate and output-port controls, one instruction at a time.
// PARAMETERS
//  DATA_W   4  datapath / immediate width
//  RADDR_W  2  register-file address width
//  CNT_W    8  retired-instruction counter width
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-low reset
//  instr_valid  in   1        instruction source has an instruction on the data bus
//  instr_ready  out  1        controller can accept; high only in IDLE
//  ir_ena       out  1        instruction register load strobe
//  ir_mnm       in   2        IR field [7:6]
//  ir_wam       in   2        IR field [5:4], write address or mnemonic LSBs
//  ir_rdw       in   DATA_W   IR field [3:0], {rdA,rdB} or immediate
//  rf_rd_a      out  RADDR_W  register-file read port A address
//  rf_rd_b      out  RADDR_W  register-file read port B address
//  rf_wr_en     out  1        register-file write enable, single-cycle pulse
//  rf_wr_addr   out  RADDR_W  register-file write address
//  wr_sel_imm   out  1        1: write data = imm_data; 0: write data = ALU result
//  imm_data     out  DATA_W   immediate operand
//  alu_op       out  1        0: add, 1: subtract (modulo 2^DATA_W, no carry kept)
//  out_en       out  1        output port captures R[rdA]; single-cycle pulse
//  done         out  1        instruction retired; single-cycle pulse
//  illegal      out  1        reserved opcode retired as NOP; pulses with done
//  halted       out  1        HALT executed; held until reset
//  instr_count  out  CNT_W    retired instructions, incl. illegal, excl. HALT; wraps
// BEHAVIOUR
//  Reset: state IDLE; every output 0 except instr_ready=1; instr_count=0.
//  Reset mid-instruction aborts it: no write or out_en issued, count unchanged.
//  Handshake: transfer when instr_valid && instr_ready at a rising edge.
//  instr_valid low in IDLE: stay in IDLE, no strobes.
//  FSM, all outputs registered (Moore):
//   IDLE   -> LOAD on transfer
//   LOAD   ir_ena=1 for exactly one cycle -> DECODE
//   DECODE classify fields, latch rd/wr addresses and imm_data -> EXEC
//   EXEC   rf_rd_a/b valid, alu_op valid -> WB
//   WB     rf_wr_en or out_en pulse as decoded -> DONE
//   DONE   done=1, instr_count++ -> IDLE; or -> HALTED on HALT
//   HALTED halted=1, instr_ready=0; exit only by reset
//  Latency: done asserts 5 cycles after the transfer edge.
//  Next transfer possible the cycle after DONE.
//  Decode by mnm:
//   01 LDI  R[wam] <= ir_rdw     wr_sel_imm=1, rf_wr_en in WB
//   10 ADD  R[wam] <= R[rdA] + R[rdB]   rdA=ir_rdw[3:2], rdB=ir_rdw[1:0]
//   11 SUB  R[wam] <= R[rdA] - R[rdB]   alu_op=1
//   00 ext, selected by wam:
//      00 NOP
//      01 OUT  out_en in WB, rf_rd_a=rdA
//      10 HALT
//      11 reserved: illegal=1 with done, no side effects
//  Write to R[wam] where wam equals rdA/rdB is legal: operands are read in EXEC,
//  the write lands at the end of WB.
//  rf_wr_en, out_en and ir_ena are never asserted in the same cycle.
//  instr_count wraps from 2^CNT_W-1 to 0 silently.
// STRUCTURE
//  Shared package dp_pkg: mnemonic localparams (MNM_EXT, MNM_LDI, MNM_ADD,
//  MNM_SUB, EXT_NOP, EXT_OUT, EXT_HALT), ALU_ADD / ALU_SUB, FSM state encoding.
//  One sub-module: dp_decoder, combinational field decode to control bundle,
//  registered in DECODE. Everything else is flat.
// TESTING
//  1 LDI 8'h5A then 8'h63 -> rf_wr_en pulses; wr_addr=1 data 4'hA, then wr_addr=2 data 4'h3;
//    done 5 cycles after each transfer.
//  2 R1=A, R2=3, ADD 8'hB6 (R3=R1+R2) -> rf_rd_a=1, rf_rd_b=2, alu_op=0, wr 3.
//    SUB 8'hF6 -> alu_op=1.
//  3 OUT 8'h14 -> out_en one cycle with rf_rd_a=1, rf_wr_en never high;
//    reserved 8'h30 -> illegal+done, count increments.
//  4 HALT 8'h20 then instr_valid held high -> halted=1, instr_ready=0 forever;
//    rst low -> IDLE, instr_ready=1.
//  5 rst low during EXEC of ADD -> no rf_wr_en, outputs at reset values, count unchanged.
//  6 256 NOPs back-to-back -> instr_count wraps to 0; instr_ready low for exactly
//    5 cycles per instruction.

Source files
------------

// File: rtl/dp_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dp_pkg : shared encodings for the 4-bit datapath sequencer              |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package dp_pkg;

  localparam int DP_DATA_W  = 4;
  localparam int DP_RADDR_W = 2;
  localparam int DP_CNT_W   = 8;

  localparam logic [1:0] MNM_EXT  = 2'b00;
  localparam logic [1:0] MNM_LDI  = 2'b01;
  localparam logic [1:0] MNM_ADD  = 2'b10;
  localparam logic [1:0] MNM_SUB  = 2'b11;

  localparam logic [1:0] EXT_NOP  = 2'b00;
  localparam logic [1:0] EXT_OUT  = 2'b01;
  localparam logic [1:0] EXT_HALT = 2'b10;
  localparam logic [1:0] EXT_RSVD = 2'b11;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  typedef struct packed {
    logic wr_en;
    logic wr_sel_imm;
    logic alu_op;
    logic out_en;
    logic halt;
    logic illegal;
  } dp_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/datapath_controller_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | datapath_controller_if : instruction handshake and datapath controls    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface datapath_controller_if
  import dp_pkg::*;
#(
  parameter int DATA_W  = DP_DATA_W,
  parameter int RADDR_W = DP_RADDR_W,
  parameter int CNT_W   = DP_CNT_W
);
  logic               instr_valid;
  logic               instr_ready;
  logic               ir_ena;
  logic [1:0]         ir_mnm;
  logic [1:0]         ir_wam;
  logic [DATA_W-1:0]  ir_rdw;
  logic [RADDR_W-1:0] rf_rd_a;
  logic [RADDR_W-1:0] rf_rd_b;
  logic               rf_wr_en;
  logic [RADDR_W-1:0] rf_wr_addr;
  logic               wr_sel_imm;
  logic [DATA_W-1:0]  imm_data;
  logic               alu_op;
  logic               out_en;
  logic               done;
  logic               illegal;
  logic               halted;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    input  instr_valid, ir_mnm, ir_wam, ir_rdw,
    output instr_ready, ir_ena, rf_rd_a, rf_rd_b, rf_wr_en, rf_wr_addr,
           wr_sel_imm, imm_data, alu_op, out_en, done, illegal, halted,
           instr_count
  );

  modport slave (
    output instr_valid, ir_mnm, ir_wam, ir_rdw,
    input  instr_ready, ir_ena, rf_rd_a, rf_rd_b, rf_wr_en, rf_wr_addr,
           wr_sel_imm, imm_data, alu_op, out_en, done, illegal, halted,
           instr_count
  );
endinterface
`default_nettype wire

// File: rtl/dp_decoder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dp_decoder : combinational IR field decode into a control bundle        |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module dp_decoder
  import dp_pkg::*;
#(
  parameter int DATA_W  = DP_DATA_W,
  parameter int RADDR_W = DP_RADDR_W
) (
  input  logic [1:0]         mnm_i,
  input  logic [1:0]         wam_i,
  input  logic [DATA_W-1:0]  rdw_i,
  output logic [RADDR_W-1:0] rd_a_o,
  output logic [RADDR_W-1:0] rd_b_o,
  output logic [RADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0]  imm_o,
  output dp_ctrl_t           ctrl_o
);

  assign rd_a_o    = rdw_i[DATA_W-1 -: RADDR_W];
  assign rd_b_o    = rdw_i[RADDR_W-1:0];
  assign wr_addr_o = RADDR_W'(wam_i);
  assign imm_o     = rdw_i;

  always_comb begin
    ctrl_o = '0;
    case (mnm_i)
      MNM_LDI: begin
        ctrl_o.wr_en      = 1'b1;
        ctrl_o.wr_sel_imm = 1'b1;
      end
      MNM_ADD: begin
        ctrl_o.wr_en  = 1'b1;
        ctrl_o.alu_op = ALU_ADD;
      end
      MNM_SUB: begin
        ctrl_o.wr_en  = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      MNM_EXT: begin
        // wam doubles as the sub-opcode for the extended group
        case (wam_i)
          EXT_NOP:  ctrl_o.illegal = 1'b0;
          EXT_OUT:  ctrl_o.out_en  = 1'b1;
          EXT_HALT: ctrl_o.halt    = 1'b1;
          EXT_RSVD: ctrl_o.illegal = 1'b1;
          default:  ctrl_o.illegal = 1'b0;
        endcase
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/datapath_controller.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | datapath_controller : multi-cycle Moore sequencer for the 4-bit datapath|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module datapath_controller
  import dp_pkg::*;
#(
  parameter int DATA_W  = DP_DATA_W,
  parameter int RADDR_W = DP_RADDR_W,
  parameter int CNT_W   = DP_CNT_W
) (
  input  logic clk,
  input  logic rst,
  datapath_controller_if.master bus
);

  logic [2:0]         state_q, state_d;
  logic [RADDR_W-1:0] dec_rd_a, dec_rd_b, dec_wr_addr;
  logic [DATA_W-1:0]  dec_imm;
  dp_ctrl_t           dec_ctrl;

  logic [RADDR_W-1:0] rd_a_q, rd_b_q, wr_addr_q;
  logic [DATA_W-1:0]  imm_q;
  dp_ctrl_t           ctrl_q;
  logic               ready_q, ir_ena_q, wr_en_q, out_en_q;
  logic               done_q, illegal_q, halted_q;
  logic [CNT_W-1:0]   count_q;

  dp_decoder #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_decoder (
    .mnm_i     (bus.ir_mnm),
    .wam_i     (bus.ir_wam),
    .rdw_i     (bus.ir_rdw),
    .rd_a_o    (dec_rd_a),
    .rd_b_o    (dec_rd_b),
    .wr_addr_o (dec_wr_addr),
    .imm_o     (dec_imm),
    .ctrl_o    (dec_ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.instr_valid) state_d = S_LOAD;
      S_LOAD:   state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_DONE;
      S_DONE:   state_d = ctrl_q.halt ? S_HALTED : S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each lines up with its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      ir_ena_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      out_en_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == S_IDLE);
      ir_ena_q  <= (state_d == S_LOAD);
      wr_en_q   <= (state_d == S_WB) && ctrl_q.wr_en;
      out_en_q  <= (state_d == S_WB) && ctrl_q.out_en;
      done_q    <= (state_d == S_DONE);
      illegal_q <= (state_d == S_DONE) && ctrl_q.illegal;
      halted_q  <= (state_d == S_HALTED);
      if ((state_d == S_DONE) && !ctrl_q.halt) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      wr_addr_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
    end else if (state_q == S_DECODE) begin
      rd_a_q    <= dec_rd_a;
      rd_b_q    <= dec_rd_b;
      wr_addr_q <= dec_wr_addr;
      imm_q     <= dec_imm;
      ctrl_q    <= dec_ctrl;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.ir_ena      = ir_ena_q;
  assign bus.rf_rd_a     = rd_a_q;
  assign bus.rf_rd_b     = rd_b_q;
  assign bus.rf_wr_en    = wr_en_q;
  assign bus.rf_wr_addr  = wr_addr_q;
  assign bus.wr_sel_imm  = ctrl_q.wr_sel_imm;
  assign bus.imm_data    = imm_q;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.out_en      = out_en_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_controller.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_datapath_controller : directed self-checking bench                   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_datapath_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] instr_data = 8'h00;
  logic [7:0] ir_q = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         exp_count = 0;

  datapath_controller_if #(.DATA_W(4), .RADDR_W(2), .CNT_W(8)) bus ();

  datapath_controller #(.DATA_W(4), .RADDR_W(2), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction register owned by the datapath side.
  always @(posedge clk) if (bus.ir_ena) ir_q <= instr_data;
  assign bus.ir_mnm = ir_q[7:6];
  assign bus.ir_wam = ir_q[5:4];
  assign bus.ir_rdw = ir_q[3:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the transfer edge, i.e. in LOAD.
  task automatic send(input logic [7:0] instr);
    int n;
    n = 0;
    instr_data      = instr;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 20) begin
      step();
      n++;
    end
    chk("xfer_wait", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic run(input logic [7:0] instr, input logic exp_wr, input logic exp_out,
                     input logic exp_ill, input logic exp_halt);
    send(instr);
    chk("ir_ena_load", bus.ir_ena, 1'b1);
    chk("ready_busy", bus.instr_ready, 1'b0);
    step();
    chk("ir_ena_single", bus.ir_ena, 1'b0);
    step();
    chk("exec_quiet", {bus.rf_wr_en, bus.out_en, bus.done}, 3'b000);
    step();
    chk("wb_wr_en", bus.rf_wr_en, exp_wr);
    chk("wb_out_en", bus.out_en, exp_out);
    chk("wb_no_done", bus.done, 1'b0);
    step();
    chk("done", bus.done, 1'b1);
    chk("illegal", bus.illegal, exp_ill);
    chk("done_no_strobe", {bus.rf_wr_en, bus.out_en}, 2'b00);
    if (!exp_halt) exp_count = (exp_count + 1) % 256;
    chk("count", bus.instr_count, exp_count);
    step();
    chk("done_pulse", bus.done, 1'b0);
    chk("ready_after", bus.instr_ready, !exp_halt);
    chk("halted", bus.halted, exp_halt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.instr_valid = 1'b0;
    step();
    step();
    chk("rst_ready", bus.instr_ready, 1'b1);
    chk("rst_strobes", {bus.ir_ena, bus.rf_wr_en, bus.out_en, bus.done,
                        bus.illegal, bus.halted}, 6'b0);
    chk("rst_count", bus.instr_count, 8'h00);
    chk("rst_fields", {bus.rf_rd_a, bus.rf_rd_b, bus.rf_wr_addr, bus.imm_data,
                       bus.wr_sel_imm, bus.alu_op}, 12'h000);
    rst = 1'b1;
    step();
    step();
    chk("idle_no_valid", {bus.instr_ready, bus.ir_ena}, 2'b10);

    // LDI R1 <= A, LDI R2 <= 3
    run(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ldi1_addr", bus.rf_wr_addr, 2'd1);
    chk("ldi1_imm", bus.imm_data, 4'hA);
    chk("ldi1_sel", bus.wr_sel_imm, 1'b1);
    run(8'h63, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ldi2_addr", bus.rf_wr_addr, 2'd2);
    chk("ldi2_imm", bus.imm_data, 4'h3);

    // ADD R3 = R1 + R2, SUB R3 = R1 - R2
    run(8'hB6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("add_rd", {bus.rf_rd_a, bus.rf_rd_b}, 4'b0110);
    chk("add_op", bus.alu_op, 1'b0);
    chk("add_wr", {bus.rf_wr_addr, bus.wr_sel_imm}, 3'b110);
    run(8'hF6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sub_op", bus.alu_op, 1'b1);
    chk("sub_rd", {bus.rf_rd_a, bus.rf_rd_b}, 4'b0110);

    // OUT R1, then reserved opcode
    run(8'h14, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("out_rd_a", bus.rf_rd_a, 2'd1);
    run(8'h30, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("count_after_rsvd", bus.instr_count, 8'd6);

    // HALT with valid held high, then reset out of it
    run(8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    instr_data      = 8'h5A;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("halt_hold", {bus.halted, bus.instr_ready, bus.ir_ena, bus.done}, 4'b1000);
    end
    chk("halt_count", bus.instr_count, 8'd6);
    bus.instr_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("halt_rst", {bus.halted, bus.instr_ready}, 2'b01);
    chk("halt_rst_count", bus.instr_count, 8'd0);
    step();
    rst = 1'b1;
    exp_count = 0;
    step();

    // Reset asserted during EXEC of an ADD
    send(8'hB6);
    step();
    step();
    chk("abort_exec_rd", bus.rf_rd_a, 2'd1);
    rst = 1'b0;
    #1;
    chk("abort_rst", {bus.instr_ready, bus.rf_wr_en, bus.ir_ena, bus.done}, 4'b1000);
    chk("abort_fields", {bus.rf_rd_a, bus.rf_rd_b}, 4'b0000);
    chk("abort_count", bus.instr_count, 8'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_quiet", {bus.rf_wr_en, bus.out_en, bus.done}, 3'b000);
    end

    // 256 back-to-back NOPs: count wraps, ready low 5 cycles each
    instr_data      = 8'h00;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      int low;
      low = 0;
      step();
      while (!bus.instr_ready && low < 10) begin
        low++;
        step();
      end
      chk("nop_ready_low", low, 5);
      if (i == 254) chk("nop_count_ff", bus.instr_count, 8'hFF);
    end
    bus.instr_valid = 1'b0;
    chk("nop_count_wrap", bus.instr_count, 8'h00);
    step();
    chk("nop_idle", bus.instr_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
